// File: rtl/wr_ps_ddr3_if.sv
// wr_ps_ddr3_if: AXI DataMover S2MM command, data and status streams
interface wr_ps_ddr3_if;
  logic        m_axis_s2mm_cmd_tvalid;
  logic        m_axis_s2mm_cmd_tready;
  logic [71:0] m_axis_s2mm_cmd_tdata;
  logic        s_axis_s2mm_tvalid;
  logic        s_axis_s2mm_tready;
  logic [31:0] s_axis_s2mm_tdata;
  logic [3:0]  s_axis_s2mm_tkeep;
  logic        s_axis_s2mm_tlast;
  logic        m_axis_s2mm_sts_tvalid;
  logic [7:0]  m_axis_s2mm_sts_tdata;
  logic        m_axis_s2mm_sts_tready;
  modport master (
    output m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata, s_axis_s2mm_tvalid, s_axis_s2mm_tdata,
           s_axis_s2mm_tkeep, s_axis_s2mm_tlast, m_axis_s2mm_sts_tready,
    input  m_axis_s2mm_cmd_tready, s_axis_s2mm_tready, m_axis_s2mm_sts_tvalid, m_axis_s2mm_sts_tdata
  );
  modport slave (
    input  m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tdata, s_axis_s2mm_tvalid, s_axis_s2mm_tdata,
           s_axis_s2mm_tkeep, s_axis_s2mm_tlast, m_axis_s2mm_sts_tready,
    output m_axis_s2mm_cmd_tready, s_axis_s2mm_tready, m_axis_s2mm_sts_tvalid, m_axis_s2mm_sts_tdata
  );
endinterface

// File: rtl/wr_ps_ddr3.sv
// wr_ps_ddr3: PS-DDR3 write engine feeding the DataMover S2MM channel from a FWFT word FIFO
module wr_ps_ddr3 #(
  parameter int   FIFO_AW = 4,
  parameter logic W_TYPE  = 1'b1,
  parameter logic EOF     = 1'b1
) (
  input  logic        clk_ps,
  input  logic        rst_n,
  input  logic        ps_ddr_wr_start,
  input  logic [31:0] ps_ddr_wr_addr,
  input  logic [31:0] ps_ddr_wr_length,
  input  logic        ps_ddr_wr_en,
  input  logic [31:0] ps_ddr_wr_data,
  output logic        ps_ddr_wr_full,
  output logic        ps_ddr_wr_ovf,
  output logic        ps_ddr_wr_busy,
  output logic        ps_ddr_wr_done,
  output logic        ps_ddr_wr_err,
  wr_ps_ddr3_if.master dm
);
  localparam logic [FIFO_AW:0] DEPTH = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic [2:0] {IDLE, CMD, DATA, STS, ERRDONE} state_t;
  state_t state, state_n;
  logic del1, del2, acc, push, pop, done_n, err_n, unused_bits;
  logic [22:0] len, btt;
  logic [20:0] beats;
  logic [FIFO_AW:0] cnt;
  logic [FIFO_AW-1:0] wp, rp;
  logic [31:0] mem [2**FIFO_AW];
  logic [7:0] sts;
  logic [3:0] keep_last;
  assign len = ps_ddr_wr_length[22:0];
  assign sts = dm.m_axis_s2mm_sts_tdata;
  assign unused_bits = ^{ps_ddr_wr_length[31:23], sts[3:0]};
  assign acc = del1 & ~del2 & (state == IDLE);
  assign ps_ddr_wr_full = cnt == DEPTH;
  assign ps_ddr_wr_busy = state != IDLE;
  assign push = ps_ddr_wr_en & ~ps_ddr_wr_full;
  assign pop = dm.s_axis_s2mm_tvalid & dm.s_axis_s2mm_tready;
  assign keep_last = btt[1:0] == 2'd1 ? 4'h1 : btt[1:0] == 2'd2 ? 4'h3 : btt[1:0] == 2'd3 ? 4'h7 : 4'hF;
  assign dm.m_axis_s2mm_cmd_tvalid = state == CMD;
  assign dm.m_axis_s2mm_sts_tready = state == STS;
  assign dm.s_axis_s2mm_tvalid = state == DATA && cnt != '0;
  assign dm.s_axis_s2mm_tdata = dm.s_axis_s2mm_tvalid ? mem[rp] : '0;
  assign dm.s_axis_s2mm_tlast = state == DATA && beats == 21'd1;
  assign dm.s_axis_s2mm_tkeep = state != DATA ? 4'h0 : dm.s_axis_s2mm_tlast ? keep_last : 4'hF;
  always_comb begin
    state_n = state;
    done_n = 1'b0;
    err_n = 1'b0;
    case (state)
      IDLE: if (acc) state_n = len == '0 ? ERRDONE : CMD;
      CMD: if (dm.m_axis_s2mm_cmd_tready) state_n = DATA;
      DATA: if (pop && dm.s_axis_s2mm_tlast) state_n = STS;
      STS: if (dm.m_axis_s2mm_sts_tvalid) begin
        state_n = IDLE;
        done_n = 1'b1;
        err_n = ~sts[7] | (|sts[6:4]);
      end
      ERRDONE: begin
        state_n = IDLE;
        done_n = 1'b1;
        err_n = 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk_ps or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      del1 <= 1'b0;
      del2 <= 1'b0;
      ps_ddr_wr_done <= 1'b0;
      ps_ddr_wr_err <= 1'b0;
      ps_ddr_wr_ovf <= 1'b0;
      btt <= '0;
      beats <= '0;
      cnt <= '0;
      wp <= '0;
      rp <= '0;
      dm.m_axis_s2mm_cmd_tdata <= '0;
    end else begin
      state <= state_n;
      del1 <= ps_ddr_wr_start;
      del2 <= del1;
      ps_ddr_wr_done <= done_n;
      ps_ddr_wr_err <= err_n;
      // a drop in the same cycle as the clearing rise still leaves ovf set
      ps_ddr_wr_ovf <= (ps_ddr_wr_ovf & ~acc) | (ps_ddr_wr_en & ps_ddr_wr_full);
      cnt <= cnt + (FIFO_AW+1)'(push) - (FIFO_AW+1)'(pop);
      wp <= wp + FIFO_AW'(push);
      rp <= rp + FIFO_AW'(pop);
      if (acc) begin
        btt <= len;
        dm.m_axis_s2mm_cmd_tdata <= {8'h00, ps_ddr_wr_addr, 1'b0, EOF, 6'b0, W_TYPE, len};
      end
      beats <= state == CMD && dm.m_axis_s2mm_cmd_tready ? btt[22:2] + 21'(|btt[1:0])
             : pop && beats != '0 ? beats - 21'd1 : beats;
    end
  always_ff @(posedge clk_ps)
    if (push) mem[wp] <= ps_ddr_wr_data;
endmodule

// File: tb/tb_wr_ps_ddr3.sv
// tb_wr_ps_ddr3: transaction-level model with per-cycle compare plus directed literal checks
module tb_wr_ps_ddr3;
  logic clk_ps = 0, rst_n = 0, start = 0, wr_en = 0;
  logic [31:0] addr = 0, length = 0, wdata = 0;
  logic full, ovf, busy, done, err;
  wr_ps_ddr3_if dm();
  wr_ps_ddr3 dut (
    .clk_ps(clk_ps), .rst_n(rst_n), .ps_ddr_wr_start(start), .ps_ddr_wr_addr(addr),
    .ps_ddr_wr_length(length), .ps_ddr_wr_en(wr_en), .ps_ddr_wr_data(wdata),
    .ps_ddr_wr_full(full), .ps_ddr_wr_ovf(ovf), .ps_ddr_wr_busy(busy),
    .ps_ddr_wr_done(done), .ps_ddr_wr_err(err), .dm(dm)
  );
  always #5 clk_ps = ~clk_ps;
  int vecs = 0, errs = 0;
  bit rnd = 0;
  logic [31:0] last_data = 0;
  logic [3:0] last_keep = 0;
  logic [31:0] mq[$];
  bit m_ovf, m_busy, m_done, m_err, cmd_pend, data_on, sts_pend, errdone, sp;
  bit busy_now, full_now, hs;
  int left, cyc = 0, det_cyc = -1, ml;
  logic [71:0] m_cmd;
  task automatic chk(input string n, input logic [71:0] a, input logic [71:0] e);
    vecs++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  always @(negedge clk_ps) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", ovf, 0);
      chk("rst_cmd_tvalid", dm.m_axis_s2mm_cmd_tvalid, 0);
      chk("rst_cmd_tdata", dm.m_axis_s2mm_cmd_tdata, 0);
      chk("rst_tvalid", dm.s_axis_s2mm_tvalid, 0);
      chk("rst_tdata", dm.s_axis_s2mm_tdata, 0);
      chk("rst_tkeep", dm.s_axis_s2mm_tkeep, 0);
      chk("rst_tlast", dm.s_axis_s2mm_tlast, 0);
      chk("rst_sts_tready", dm.m_axis_s2mm_sts_tready, 0);
      mq.delete();
      {m_ovf, m_busy, m_done, m_err, cmd_pend, data_on, sts_pend, errdone, sp} = '0;
      det_cyc = -1;
    end else begin
      busy_now = m_busy;
      full_now = mq.size() == 16;
      hs = dm.s_axis_s2mm_tvalid && dm.s_axis_s2mm_tready;
      chk("done", done, m_done);
      if (m_done) chk("err", err, m_err);
      chk("busy", busy, m_busy);
      chk("full", full, full_now);
      chk("ovf", ovf, m_ovf);
      chk("cmd_tvalid", dm.m_axis_s2mm_cmd_tvalid, cmd_pend);
      if (cmd_pend) chk("cmd_tdata", dm.m_axis_s2mm_cmd_tdata, m_cmd);
      chk("tvalid", dm.s_axis_s2mm_tvalid, data_on && mq.size() > 0);
      chk("sts_tready", dm.m_axis_s2mm_sts_tready, sts_pend);
      m_done = 0;
      if (errdone) begin
        errdone = 0; m_busy = 0; m_done = 1; m_err = 1;
      end
      if (sts_pend && dm.m_axis_s2mm_sts_tvalid) begin
        sts_pend = 0; m_busy = 0; m_done = 1;
        m_err = dm.m_axis_s2mm_sts_tdata < 8'h80 || (dm.m_axis_s2mm_sts_tdata & 8'h70) != 0;
      end
      if (hs && data_on && mq.size() > 0) begin
        chk("tdata", dm.s_axis_s2mm_tdata, mq[0]);
        chk("tlast", dm.s_axis_s2mm_tlast, left == 1);
        chk("tkeep", dm.s_axis_s2mm_tkeep, (left == 1 && ml % 4 != 0) ? (1 << (ml % 4)) - 1 : 15);
        if (dm.s_axis_s2mm_tlast) begin
          last_data = dm.s_axis_s2mm_tdata;
          last_keep = dm.s_axis_s2mm_tkeep;
        end
        void'(mq.pop_front());
        left--;
        if (left == 0) begin data_on = 0; sts_pend = 1; end
      end
      if (cmd_pend && dm.m_axis_s2mm_cmd_tready) begin
        cmd_pend = 0; data_on = 1; left = (ml + 3) / 4;
      end
      if (cyc == det_cyc && !busy_now) begin
        ml = int'(length[22:0]);
        m_cmd = {8'h00, addr, 8'h40, 1'b1, length[22:0]};
        m_ovf = 0; m_busy = 1;
        if (ml == 0) errdone = 1; else cmd_pend = 1;
      end
      if (wr_en) begin
        if (full_now) m_ovf = 1; else mq.push_back(wdata);
      end
      if (start && !sp) det_cyc = cyc + 1;
      sp = start;
    end
  end
  task automatic tick;
    @(posedge clk_ps);
    #2;
    if (rnd) dm.s_axis_s2mm_tready = 1'($urandom_range(0, 1));
  endtask
  task automatic push_words(input logic [31:0] base, input logic [31:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1;
      wdata = base + step * i;
      tick;
    end
    wr_en = 0;
  endtask
  task automatic start_xfer(input logic [31:0] a, input logic [31:0] l);
    addr = a;
    length = l;
    start = 1;
    tick;
    tick;
    start = 0;
  endtask
  task automatic wait_done(input int lim, output logic e);
    bit got;
    got = 0;
    e = 0;
    for (int i = 0; i < lim && !got; i++) begin
      tick;
      if (done) begin got = 1; e = err; end
    end
    chk("done_seen", got, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic e;
    bit seen;
    dm.m_axis_s2mm_cmd_tready = 1;
    dm.s_axis_s2mm_tready = 1;
    dm.m_axis_s2mm_sts_tvalid = 1;
    dm.m_axis_s2mm_sts_tdata = 8'h80;
    repeat (3) tick;
    rst_n = 1;
    tick;
    push_words(32'h1111_1111, 32'h1111_1111, 4);
    start_xfer(32'h1000_0000, 16);
    wait_done(100, e);
    chk("t1_err", e, 0);
    chk("t1_cmd", dm.m_axis_s2mm_cmd_tdata, 72'h00_10000000_40_800010);
    chk("t1_last_data", last_data, 32'h4444_4444);
    chk("t1_last_keep", last_keep, 4'hF);
    push_words(32'hA000_0001, 1, 2);
    start_xfer(32'h2000_0004, 6);
    wait_done(100, e);
    chk("t2_err", e, 0);
    chk("t2_cmd", dm.m_axis_s2mm_cmd_tdata, 72'h00_20000004_40_800006);
    chk("t2_last_data", last_data, 32'hA000_0002);
    chk("t2_last_keep", last_keep, 4'h3);
    push_words(32'hB000_0000, 1, 4);
    dm.m_axis_s2mm_cmd_tready = 0;
    rnd = 1;
    start_xfer(32'h3000_0000, 13);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) if (dm.m_axis_s2mm_cmd_tvalid) seen = 1; else tick;
    chk("t3_cmd_seen", seen, 1);
    repeat (5) tick;
    chk("t3_cmd_hold", dm.m_axis_s2mm_cmd_tvalid, 1);
    chk("t3_cmd_stable", dm.m_axis_s2mm_cmd_tdata, 72'h00_30000000_40_80000D);
    dm.m_axis_s2mm_cmd_tready = 1;
    wait_done(200, e);
    rnd = 0;
    dm.s_axis_s2mm_tready = 1;
    chk("t3_err", e, 0);
    chk("t3_last_data", last_data, 32'hB000_0003);
    chk("t3_last_keep", last_keep, 4'h1);
    push_words(32'hC000_0000, 1, 17);
    chk("t4_full", full, 1);
    chk("t4_ovf", ovf, 1);
    start_xfer(32'h4000_0000, 64);
    chk("t4_ovf_clr", ovf, 0);
    wait_done(200, e);
    chk("t4_err", e, 0);
    chk("t4_last_data", last_data, 32'hC000_000F);
    chk("t4_empty_full", full, 0);
    start_xfer(32'h5000_0000, 0);
    wait_done(20, e);
    chk("t5_zero_len_err", e, 1);
    dm.m_axis_s2mm_sts_tdata = 8'hC0;
    push_words(32'hD000_0000, 1, 1);
    start_xfer(32'h6000_0000, 4);
    wait_done(100, e);
    chk("t6_slverr", e, 1);
    dm.m_axis_s2mm_sts_tdata = 8'h80;
    push_words(32'hE000_0000, 1, 2);
    dm.s_axis_s2mm_tready = 0;
    start_xfer(32'h7000_0000, 32);
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) if (dm.s_axis_s2mm_tvalid) seen = 1; else tick;
    chk("t7_data_seen", seen, 1);
    rst_n = 0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_tvalid", dm.s_axis_s2mm_tvalid, 0);
    chk("t7_done", done, 0);
    tick;
    tick;
    rst_n = 1;
    dm.s_axis_s2mm_tready = 1;
    repeat (4) tick;
    chk("t7_full", full, 0);
    push_words(32'hF000_0000, 1, 4);
    start_xfer(32'h8000_0000, 16);
    wait_done(100, e);
    chk("t7_err", e, 0);
    chk("t7_last_data", last_data, 32'hF000_0003);
    repeat (3) tick;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
